carry_select_sub_pipe: RTL and testbench
========================================

Name: carry_select_sub_pipe

Overview:
- Pipelined unsigned subtractor: diff = a - b, built from carry-select segments, one segment resolved per pipeline stage.
- Computes a + ~b + 1 per segment. Each segment precomputes both carry-in hypotheses and muxes on the registered carry from the previous stage.
- Streaming valid/ready interface on both sides, so the unit can sit between an operand source and a result sink in the ALU datapath.
- It is the inverse-direction companion of the combinational carry-select adder model, and is checked against the same 24-bit random-operand methodology.

Parameters:
- DATA_WIDTH, 24, operand and difference width in bits; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8, carry-select segment width; NUM_SEG = DATA_WIDTH/SEG_WIDTH is the pipeline depth (default 3).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  DATA_WIDTH  minuend, unsigned.
- b  input  DATA_WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff/borrow are valid.
- out_ready  input  1  sink accepts the result this cycle.
- diff  output  DATA_WIDTH  (a - b) mod 2^DATA_WIDTH.
- borrow  output  1  1 iff a < b (unsigned), i.e. the final carry-out is 0.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, diff=0, borrow=0. All stage valid bits, partial-result registers and carry registers clear to 0. in_ready=1 in the cycle after reset.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline advance: advance = !out_valid || out_ready, applied globally to all stages.
  - in_ready = advance (combinational).
  - When advance=0, every stage register holds, including operands, partial diff and carry.
  - Bubbles do not collapse during a stall.
- Stage k (k = 0..NUM_SEG-1):
  - Operates on segment bits [k*SEG_WIDTH +: SEG_WIDTH] of the a and b values carried down the pipe.
  - Forms s0 = a_seg + ~b_seg + 0 and s1 = a_seg + ~b_seg + 1, each SEG_WIDTH+1 bits wide.
  - Selects s1 if cin=1, else s0.
  - Carry-in: cin for stage 0 is the constant 1 (two's-complement +1). cin for stage k>0 is the carry register written by stage k-1.
  - On advance, stage k registers the selected low SEG_WIDTH bits into its slice of the partial diff, registers the selected MSB as the carry for stage k+1, and passes through the unused upper operand bits.
- Outputs:
  - The final stage drives diff directly from its register.
  - borrow = ~final carry.
  - out_valid = final-stage valid bit.
- Latency: exactly NUM_SEG cycles from input transfer to out_valid (3 at defaults) when out_ready stays 1. Throughput is 1 result/cycle.
- Ordering: results leave strictly in input order; no drops or duplicates.
- Stall boundary: out_valid=1 && out_ready=0 forces in_ready=0. diff/borrow must stay stable until the transfer.
- Simultaneous: out_ready=1 with in_valid=1 in the same cycle gives one result out and one operand in, with no bubble.
- Reset mid-operation: rst has priority over advance. All in-flight results are discarded (never presented), out_valid=0 on the next cycle, and nothing issued before rst appears afterward.
- Boundary values:
  - a == b gives diff=0, borrow=0.
  - a=0, b=max gives diff=1, borrow=1.
  - A borrow must ripple correctly across every segment boundary.

Test Plan:
- Reset, then a=100, b=20, out_ready=1 -> out_valid rises 3 cycles after transfer; diff=80, borrow=0.
- a=0, b=1 -> diff=0xFFFFFF, borrow=1. Then a=0x123456, b=0x123456 -> diff=0, borrow=0.
- Cross-segment borrow: a=0x010000, b=0x000001 -> diff=0x00FFFF, borrow=0. Also a=0x00FF00, b=0x000100 -> diff=0x00FE00, borrow=0.
- Streaming: 32 back-to-back random 24-bit pairs (from $urandom masked to 24 bits), out_ready=1 -> 32 consecutive out_valid cycles starting at cycle 3. Each diff matches (a-b) mod 2^24 and each borrow matches (a<b), in order.
- Backpressure: stream 8 pairs with out_ready toggled 1,0,0,1 repeating -> in_ready=0 whenever out_valid && !out_ready; diff held stable during the stall; all 8 results correct and in order.
- Reset mid-stream: assert rst for 1 cycle while 3 results are in flight -> out_valid=0 next cycle. The next accepted pair a=5, b=7 yields diff=0xFFFFFE, borrow=1 as the first output.

Source files
------------

// File: rtl/carry_select_sub_pipe_if.sv
// ---------------------------------------------------------------------------
// carry_select_sub_pipe_if
//
// Streaming bus of the pipelined carry-select subtractor.
//
// Handshake: a beat moves across a side exactly in a cycle where that side's
// valid and ready are both 1 at the rising clock edge. The producer holds
// its valid and payload steady until the beat moves, and it never waits on
// ready before raising valid. Ready may depend combinationally on the other
// side's state but never on the valid of the same side.
//
// Signals
//   in_valid  : operands a/b are valid this cycle          (source -> unit)
//   in_ready  : the unit accepts operands this cycle       (unit -> source)
//   a, b      : minuend / subtrahend, unsigned             (source -> unit)
//   out_valid : diff/borrow are valid                      (unit -> sink)
//   out_ready : the sink accepts the result this cycle     (sink -> unit)
//   diff      : (a - b) mod 2^DATA_WIDTH                   (unit -> sink)
//   borrow    : 1 iff a < b (unsigned)                     (unit -> sink)
//
// Modports
//   master : the environment around the unit (operand source + result sink)
//   slave  : the subtractor itself
// ---------------------------------------------------------------------------
interface carry_select_sub_pipe_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow
  );
endinterface

// File: rtl/carry_select_sub_pipe.sv
// ---------------------------------------------------------------------------
// carry_select_sub_pipe
//
// Pipelined unsigned subtractor, diff = a - b, computed as a + ~b + 1.
// The operands are split into NUM_SEG = DATA_WIDTH / SEG_WIDTH segments and
// one segment is resolved per pipeline stage. Each stage precomputes its
// segment sum for both carry-in hypotheses and selects one with the carry
// registered by the previous stage. Stage 0 has carry-in 1, which supplies
// the +1 of the two's-complement negation of b.
//
// DATA_WIDTH must be a multiple of SEG_WIDTH.
//
// Latency is NUM_SEG cycles from the input transfer to out_valid. Throughput
// is one result per cycle while the sink keeps out_ready high.
//
// Ports
//   clk : clock, all state changes on the rising edge
//   rst : synchronous reset, active high; in-flight results are discarded
//   bus : carry_select_sub_pipe_if.slave
//         in_valid/in_ready/a/b         operand side
//         out_valid/out_ready/diff/borrow result side
// ---------------------------------------------------------------------------
module carry_select_sub_pipe #(
  parameter int DATA_WIDTH = 24,
  parameter int SEG_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  carry_select_sub_pipe_if.slave    bus
);

  localparam int NUM_SEG = DATA_WIDTH / SEG_WIDTH;
  localparam int LAST    = NUM_SEG - 1;

  // -------------------------------------------------------------------------
  // Stage registers. Index k holds what stage k produced on its last advance.
  // a/b travel with the result so later stages can still see their segment.
  // diff_q[k] has segments 0..k resolved; higher segments are still zero.
  // carry_q[k] is the carry-out of segment k, i.e. carry-in of stage k+1.
  // -------------------------------------------------------------------------
  logic                  valid_q [NUM_SEG];
  logic [DATA_WIDTH-1:0] a_q     [NUM_SEG];
  logic [DATA_WIDTH-1:0] b_q     [NUM_SEG];
  logic [DATA_WIDTH-1:0] diff_q  [NUM_SEG];
  logic                  carry_q [NUM_SEG];

  // Inputs seen by each stage: stage 0 reads the bus, stage k reads k-1.
  logic                  src_valid [NUM_SEG];
  logic [DATA_WIDTH-1:0] src_a     [NUM_SEG];
  logic [DATA_WIDTH-1:0] src_b     [NUM_SEG];
  logic [DATA_WIDTH-1:0] src_diff  [NUM_SEG];
  logic                  src_cin   [NUM_SEG];

  // Per-segment sums for carry-in 0 and carry-in 1, and the selected one.
  logic [SEG_WIDTH:0]    sum0 [NUM_SEG];
  logic [SEG_WIDTH:0]    sum1 [NUM_SEG];
  logic [SEG_WIDTH:0]    sel  [NUM_SEG];

  // -------------------------------------------------------------------------
  // Global advance. The whole pipe moves together or holds together, so a
  // stall freezes bubbles in place instead of squeezing them out; this keeps
  // the handshake trivially correct and the timing of in_ready shallow.
  // -------------------------------------------------------------------------
  logic advance;

  assign advance      = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  // -------------------------------------------------------------------------
  // Stage datapath
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid[k] = bus.in_valid;
      assign src_a[k]     = bus.a;
      assign src_b[k]     = bus.b;
      assign src_diff[k]  = '0;
      // Two's-complement +1 enters as the carry-in of the lowest segment.
      assign src_cin[k]   = 1'b1;
    end else begin : g_body
      assign src_valid[k] = valid_q[k-1];
      assign src_a[k]     = a_q[k-1];
      assign src_b[k]     = b_q[k-1];
      assign src_diff[k]  = diff_q[k-1];
      assign src_cin[k]   = carry_q[k-1];
    end

    // Both hypotheses are ready before the carry arrives; only the final
    // 2:1 select waits on the previous stage's carry register.
    assign sum0[k] = {1'b0, src_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
                   + {1'b0, ~src_b[k][k*SEG_WIDTH +: SEG_WIDTH]};
    assign sum1[k] = sum0[k] + (SEG_WIDTH+1)'(1);
    assign sel[k]  = src_cin[k] ? sum1[k] : sum0[k];
  end

  // -------------------------------------------------------------------------
  // Stage registers. Reset wins over advance so a reset mid-stream discards
  // every in-flight result.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SEG; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        diff_q[k]  <= '0;
        carry_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < NUM_SEG; k++) begin
        valid_q[k] <= src_valid[k];
        a_q[k]     <= src_a[k];
        b_q[k]     <= src_b[k];
        // Copy the segments already resolved, then overwrite this stage's
        // slice; the later non-blocking write takes precedence.
        diff_q[k]  <= src_diff[k];
        diff_q[k][k*SEG_WIDTH +: SEG_WIDTH] <= sel[k][SEG_WIDTH-1:0];
        carry_q[k] <= sel[k][SEG_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs straight from the final stage register. A carry-out of 0 means
  // the subtraction borrowed. borrow is qualified with the valid bit so that
  // the idle/reset value is 0 rather than the complement of a cleared carry.
  // -------------------------------------------------------------------------
  assign bus.out_valid = valid_q[LAST];
  assign bus.diff      = diff_q[LAST];
  assign bus.borrow    = valid_q[LAST] & ~carry_q[LAST];

endmodule

// File: tb/tb_carry_select_sub_pipe.sv
module tb_carry_select_sub_pipe;

  localparam int W = 24;
  localparam logic [W-1:0] MASK = '1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  carry_select_sub_pipe_if #(.DATA_WIDTH(W)) bus ();

  carry_select_sub_pipe #(.DATA_WIDTH(W), .SEG_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------- bookkeeping
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic, {borrow, diff}.
  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W:0] wide;
    wide = {1'b0, a} - {1'b0, b};
    return {(a < b), wide[W-1:0] & MASK};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [W:0] exp_q[$];
  logic       mon_en     = 1'b0;
  logic       prev_stall = 1'b0;
  logic [W:0] prev_out   = '0;
  int         out_cnt    = 0;
  int         run_len    = 0;
  int         max_run    = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      run_len    = 0;
    end else if (mon_en) begin
      check("in_ready_rule", 32'(bus.in_ready),
            32'(!bus.out_valid || bus.out_ready));
      if (prev_stall) begin
        check("stall_valid_held", 32'(bus.out_valid), 32'(1));
        check("stall_result_held", 32'({bus.borrow, bus.diff}), 32'(prev_out));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.borrow, bus.diff};

      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no result (t=%0t)",
                   {bus.borrow, bus.diff}, $time);
        end else begin
          check("result_in_order", 32'({bus.borrow, bus.diff}),
                32'(exp_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b));

      if (bus.out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // Called at posedge+1; returns at posedge+1 right after the accepting edge,
  // with in_valid still high so back-to-back sends leave no gap.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    acc = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'(1));
  endtask

  task automatic apply_vec(input string name, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] ed,
                           input logic eb);
    int cyc;
    bus.out_ready = 1'b1;
    send(a, b);
    bus.in_valid = 1'b0;
    cyc = 0;
    for (int t = 1; t <= 20 && cyc == 0; t++) begin
      @(negedge clk);
      if (bus.out_valid) cyc = t;
    end
    check({name, "_latency"}, 32'(cyc), 32'(3));
    if (cyc != 0) begin
      check({name, "_diff"}, 32'(bus.diff), 32'(ed));
      check({name, "_borrow"}, 32'(bus.borrow), 32'(eb));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic ready_pattern(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{"basic",       24'd100,    24'd20,     24'd80,     1'b0};
    vecs[1] = '{"zero_minus1", 24'h000000, 24'h000001, 24'hFFFFFF, 1'b1};
    vecs[2] = '{"equal",       24'h123456, 24'h123456, 24'h000000, 1'b0};
    vecs[3] = '{"xseg_2to1",   24'h010000, 24'h000001, 24'h00FFFF, 1'b0};
    vecs[4] = '{"xseg_1",      24'h00FF00, 24'h000100, 24'h00FE00, 1'b0};
    vecs[5] = '{"zero_max",    24'h000000, 24'hFFFFFF, 24'h000001, 1'b1};
    vecs[6] = '{"max_zero",    24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0};
    vecs[7] = '{"msb_borrow",  24'h800000, 24'h000001, 24'h7FFFFF, 1'b0};
    vecs[8] = '{"neg_one",     24'h000100, 24'h000101, 24'hFFFFFF, 1'b1};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset and reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'(0));
    check("reset_diff", 32'(bus.diff), 32'(0));
    check("reset_borrow", 32'(bus.borrow), 32'(0));
    check("reset_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 9; i++)
      apply_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp_diff,
                vecs[i].exp_borrow);
    wait_drain("table");

    // Streaming: 32 back-to-back random pairs at full rate.
    base    = out_cnt;
    max_run = 0;
    for (int i = 0; i < 32; i++)
      send(W'($urandom) & MASK, W'($urandom) & MASK);
    bus.in_valid = 1'b0;
    wait_drain("stream");
    check("stream_count", 32'(out_cnt - base), 32'(32));
    check("stream_consecutive", 32'(max_run), 32'(32));

    // Backpressure: out_ready cycles 1,0,0,1 while 8 pairs are offered.
    base = out_cnt;
    fork
      ready_pattern(60);
      begin
        for (int i = 0; i < 8; i++)
          send(W'($urandom) & MASK, W'($urandom) & MASK);
        bus.in_valid = 1'b0;
      end
    join
    wait_drain("backpressure");
    check("backpressure_count", 32'(out_cnt - base), 32'(8));

    // Reset with three results in flight, the oldest stalled at the output.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(W'($urandom_range(1000, 50000)), W'($urandom_range(0, 40)));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_out_valid", 32'(bus.out_valid), 32'(0));
    check("post_reset_diff", 32'(bus.diff), 32'(0));
    @(posedge clk);
    #1;
    apply_vec("after_reset", 24'd5, 24'd7, 24'hFFFFFE, 1'b1);
    wait_drain("after_reset");

    // A few idle cycles to catch any stale result reappearing.
    repeat (6) @(posedge clk);
    #1;
    check("final_idle_queue", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
